cache_ctrl_burst: RTL and testbench



---
 rtl/cache_ctrl_pkg.sv | 45 ++++
 rtl/cache_line_buf.sv | 40 ++++
 rtl/cache_ctrl_burst.sv | 172 +++++++++++++++++
 tb/tb_cache_ctrl_burst.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_ctrl_pkg.sv
// Shared types and parameter helpers for the burst cache controller.
package cache_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    WR_WAIT,
    DONE
  } state_t;

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

  // CPU words per SRAM beat
  function automatic int unsigned wpb(input int unsigned sram_w, input int unsigned data_w);
    return sram_w / data_w;
  endfunction

  function automatic int unsigned word_off_lsb(input int unsigned data_w);
    return $clog2(data_w / 8);
  endfunction

  // Held at 1 bit minimum so single-word beats still have a legal select vector
  function automatic int unsigned word_off_w(input int unsigned sram_w, input int unsigned data_w);
    return (wpb(sram_w, data_w) > 1) ? $clog2(wpb(sram_w, data_w)) : 1;
  endfunction

  function automatic int unsigned beat_lsb(input int unsigned sram_w);
    return $clog2(sram_w / 8);
  endfunction

  function automatic int unsigned beat_idx_w(input int unsigned line_beats);
    return (line_beats > 1) ? $clog2(line_beats) : 1;
  endfunction

  function automatic bit params_ok(input int unsigned data_w, input int unsigned sram_w,
                                   input int unsigned line_beats);
    return (data_w % 8 == 0) && (sram_w % data_w == 0) && is_pow2(sram_w / data_w) &&
           is_pow2(line_beats) && (line_beats >= 1) && (line_beats <= 8);
  endfunction

endpackage

// File: rtl/cache_line_buf.sv
// Line-fill buffer: one register per SRAM beat plus a latch for the requested CPU word.
module cache_line_buf
  import cache_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned SRAM_DATA_W = 64,
  parameter int unsigned LINE_BEATS  = 2,
  localparam int unsigned BI_W       = beat_idx_w(LINE_BEATS),
  localparam int unsigned OFF_W      = word_off_w(SRAM_DATA_W, DATA_W)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              wr_en,
  input  logic [BI_W-1:0]                   wr_beat,
  input  logic [SRAM_DATA_W-1:0]            wr_data,
  input  logic                              latch_word,
  input  logic [OFF_W-1:0]                  word_sel,
  output logic [LINE_BEATS*SRAM_DATA_W-1:0] line_data,
  output logic [DATA_W-1:0]                 word
);

  logic [SRAM_DATA_W-1:0] beats [LINE_BEATS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < LINE_BEATS; i++) beats[i] <= '0;
      word <= '0;
    end else if (wr_en) begin
      beats[wr_beat] <= wr_data;
      if (latch_word) word <= DATA_W'(wr_data >> (32'(word_sel) * DATA_W));
    end
  end

  always_comb begin
    line_data = '0;
    for (int unsigned i = 0; i < LINE_BEATS; i++)
      line_data[i*SRAM_DATA_W +: SRAM_DATA_W] = beats[i];
  end

endmodule

// File: rtl/cache_ctrl_burst.sv
// Cache controller: combinational read hits, multi-beat line fill on miss,
// write-through with invalidate-or-update of the cached word.
module cache_ctrl_burst
  import cache_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned SRAM_DATA_W  = 64,
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned SRAM_ADDR_W  = 17,
  parameter int unsigned LINE_BEATS   = 2,
  parameter int unsigned WRITE_UPDATE = 0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [ADDR_W-1:0]                 addr,
  input  logic [DATA_W-1:0]                 wdata,
  input  logic                              mem_r_en,
  input  logic                              mem_w_en,
  output logic [DATA_W-1:0]                 rdata,
  output logic                              ready,
  output logic [SRAM_ADDR_W-1:0]            sram_addr,
  output logic [DATA_W-1:0]                 sram_wdata,
  output logic                              sram_read,
  output logic                              sram_write,
  input  logic [SRAM_DATA_W-1:0]            sram_rdata,
  input  logic                              sram_ready,
  input  logic                              hit,
  input  logic [DATA_W-1:0]                 cache_rdata,
  output logic                              cache_r_en,
  output logic                              cache_fill_en,
  output logic [ADDR_W-1:0]                 cache_fill_addr,
  output logic [LINE_BEATS*SRAM_DATA_W-1:0] cache_fill_data,
  output logic                              cache_invalidate,
  output logic                              cache_update
);

  localparam int unsigned WPB     = wpb(SRAM_DATA_W, DATA_W);
  localparam int unsigned OFF_LSB = word_off_lsb(DATA_W);
  localparam int unsigned OFF_W   = word_off_w(SRAM_DATA_W, DATA_W);
  localparam int unsigned B_LSB   = beat_lsb(SRAM_DATA_W);
  localparam int unsigned BI_W    = beat_idx_w(LINE_BEATS);

  if (!params_ok(DATA_W, SRAM_DATA_W, LINE_BEATS)) begin : g_param_err
    $error("cache_ctrl_burst: SRAM_DATA_W must be DATA_W x 2^n and LINE_BEATS a power of 2 in 1..8");
  end

  state_t state, state_nx;

  logic [BI_W-1:0]        beat;
  logic [ADDR_W-1:0]      cap_addr;
  logic [DATA_W-1:0]      cap_wdata;
  logic                   cap_hit;
  logic                   cap_read;
  logic [SRAM_ADDR_W-1:0] beat_addr;
  logic [SRAM_ADDR_W-1:0] line_base;
  logic [BI_W-1:0]        tgt_beat;
  logic [OFF_W-1:0]       word_sel;
  logic [DATA_W-1:0]      lat_word;
  logic                   last_beat;
  logic                   buf_wr;

  assign beat_addr = SRAM_ADDR_W'(cap_addr >> B_LSB);
  assign line_base = beat_addr & ~SRAM_ADDR_W'(LINE_BEATS - 1);
  assign tgt_beat  = BI_W'(beat_addr & SRAM_ADDR_W'(LINE_BEATS - 1));
  assign word_sel  = (WPB > 1) ? OFF_W'(cap_addr >> OFF_LSB) : '0;
  assign last_beat = (beat == BI_W'(LINE_BEATS - 1));
  assign buf_wr    = (state == RD_WAIT) && sram_ready;

  assign sram_wdata      = cap_wdata;
  assign cache_fill_addr = cap_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat      <= '0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_hit   <= 1'b0;
      cap_read  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_r_en && !hit) begin
            cap_addr <= addr;
            cap_read <= 1'b1;
            beat     <= '0;
          end else if (mem_w_en && !mem_r_en) begin
            cap_addr  <= addr;
            cap_wdata <= wdata;
            cap_hit   <= hit;
            cap_read  <= 1'b0;
          end
        end
        RD_WAIT: if (sram_ready && !last_beat) beat <= beat + BI_W'(1);
        default: ;
      endcase
    end
  end

  cache_line_buf #(
    .DATA_W      (DATA_W),
    .SRAM_DATA_W (SRAM_DATA_W),
    .LINE_BEATS  (LINE_BEATS)
  ) u_line_buf (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (buf_wr),
    .wr_beat    (beat),
    .wr_data    (sram_rdata),
    .latch_word (beat == tgt_beat),
    .word_sel   (word_sel),
    .line_data  (cache_fill_data),
    .word       (lat_word)
  );

  always_comb begin
    state_nx         = state;
    ready            = 1'b0;
    rdata            = '0;
    sram_addr        = '0;
    sram_read        = 1'b0;
    sram_write       = 1'b0;
    cache_r_en       = 1'b0;
    cache_fill_en    = 1'b0;
    cache_invalidate = 1'b0;
    cache_update     = 1'b0;
    case (state)
      IDLE: begin
        // Lookup enable is masked while reset is held so no strobe escapes during reset
        cache_r_en = mem_r_en & ~rst;
        if (mem_r_en) begin
          if (hit) begin
            ready = 1'b1;
            rdata = cache_rdata;
          end else begin
            state_nx = RD_REQ;
          end
        end else if (mem_w_en) begin
          state_nx = WR_REQ;
        end else begin
          ready = 1'b1;
        end
      end
      RD_REQ: begin
        sram_read = 1'b1;
        sram_addr = line_base | SRAM_ADDR_W'(beat);
        state_nx  = RD_WAIT;
      end
      RD_WAIT: if (sram_ready) state_nx = last_beat ? DONE : RD_REQ;
      WR_REQ: begin
        sram_write = 1'b1;
        sram_addr  = beat_addr;
        if (WRITE_UPDATE == 0) cache_invalidate = 1'b1;
        else                   cache_update     = cap_hit;
        state_nx = WR_WAIT;
      end
      WR_WAIT: if (sram_ready) state_nx = DONE;
      DONE: begin
        ready         = 1'b1;
        rdata         = cap_read ? lat_word : '0;
        cache_fill_en = cap_read;
        state_nx      = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_ctrl_burst.sv
// Scoreboard bench for cache_ctrl_burst: invalidate and update variants driven in lockstep.
module tb_cache_ctrl_burst;

  localparam int unsigned DW  = 32;
  localparam int unsigned SW  = 64;
  localparam int unsigned AW  = 32;
  localparam int unsigned SAW = 17;
  localparam int unsigned LB  = 2;

  logic clk = 1'b0;
  logic rst;
  logic [AW-1:0]  addr;
  logic [DW-1:0]  wdata, cache_rdata;
  logic           mem_r_en, mem_w_en, hit;
  logic [SW-1:0]  sram_rdata;
  logic           sram_ready, model_ready, glitch_ready;

  logic [DW-1:0]     rdata, sram_wdata;
  logic              ready, sram_read, sram_write, cache_r_en, cache_fill_en, cache_invalidate, cache_update;
  logic [SAW-1:0]    sram_addr;
  logic [AW-1:0]     cache_fill_addr;
  logic [LB*SW-1:0]  cache_fill_data;

  logic [DW-1:0]     u_rdata, u_sram_wdata;
  logic              u_ready, u_sram_read, u_sram_write, u_cache_r_en, u_cache_fill_en, u_cache_invalidate, u_cache_update;
  logic [SAW-1:0]    u_sram_addr;
  logic [AW-1:0]     u_cache_fill_addr;
  logic [LB*SW-1:0]  u_cache_fill_data;

  assign sram_ready = model_ready | glitch_ready;

  always #5 clk = ~clk;

  cache_ctrl_burst #(.DATA_W(DW), .SRAM_DATA_W(SW), .ADDR_W(AW), .SRAM_ADDR_W(SAW),
                     .LINE_BEATS(LB), .WRITE_UPDATE(0)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .rdata(rdata), .ready(ready), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_read(sram_read), .sram_write(sram_write), .sram_rdata(sram_rdata), .sram_ready(sram_ready),
    .hit(hit), .cache_rdata(cache_rdata), .cache_r_en(cache_r_en), .cache_fill_en(cache_fill_en),
    .cache_fill_addr(cache_fill_addr), .cache_fill_data(cache_fill_data),
    .cache_invalidate(cache_invalidate), .cache_update(cache_update));

  cache_ctrl_burst #(.DATA_W(DW), .SRAM_DATA_W(SW), .ADDR_W(AW), .SRAM_ADDR_W(SAW),
                     .LINE_BEATS(LB), .WRITE_UPDATE(1)) dut_u (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .rdata(u_rdata), .ready(u_ready), .sram_addr(u_sram_addr), .sram_wdata(u_sram_wdata),
    .sram_read(u_sram_read), .sram_write(u_sram_write), .sram_rdata(sram_rdata), .sram_ready(sram_ready),
    .hit(hit), .cache_rdata(cache_rdata), .cache_r_en(u_cache_r_en), .cache_fill_en(u_cache_fill_en),
    .cache_fill_addr(u_cache_fill_addr), .cache_fill_data(u_cache_fill_data),
    .cache_invalidate(u_cache_invalidate), .cache_update(u_cache_update));

  int checks = 0;
  int errors = 0;
  int sram_lat = 1;

  logic [SAW-1:0] exp_addr_q[$], obs_addr_q[$];
  logic [DW-1:0]  exp_rd_q[$], obs_wdata_q[$];
  logic [SAW-1:0] ea, oa;
  logic [DW-1:0]  er;

  typedef struct {
    int lat;
    logic [DW-1:0] rd;
    int n_rd, n_wr, n_fill, n_inv, n_upd, n_inv_u, n_upd_u;
  } res_t;

  res_t res;

  function automatic logic [SW-1:0] beat_data(input logic [SAW-1:0] a);
    if (a == 17'h21) return 64'hAAAA_BBBB_1111_2222;
    return {32'hA500_0000 ^ {15'b0, a}, 32'h0C00_0000 + {15'b0, a}};
  endfunction

  function automatic logic [DW-1:0] exp_word(input logic [AW-1:0] a);
    logic [SW-1:0] d;
    d = beat_data(SAW'(a >> 3));
    return a[2] ? d[63:32] : d[31:0];
  endfunction

  function automatic logic [SAW-1:0] line_base(input logic [AW-1:0] a);
    return SAW'(a >> 3) & ~17'h1;
  endfunction

  // SRAM model: answers each strobe after sram_lat cycles, abandons on reset
  initial begin : sram_model
    logic [SAW-1:0] a;
    bit abort;
    model_ready = 1'b0;
    sram_rdata  = '0;
    forever begin
      @(negedge clk);
      if (!rst && (sram_read || sram_write)) begin
        a = sram_addr;
        abort = 1'b0;
        for (int k = 0; k < sram_lat; k++) begin
          @(posedge clk);
          if (rst) abort = 1'b1;
        end
        #1;
        if (!abort && !rst) begin
          model_ready = 1'b1;
          sram_rdata  = beat_data(a);
          @(posedge clk);
          #1 model_ready = 1'b0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic run_req(input bit r, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input bit h, input logic [DW-1:0] crd, input int glitch_at, output res_t o);
    o = '{lat: -1, rd: 'x, default: 0};
    @(posedge clk); #1;
    addr = a; wdata = wd; mem_r_en = r; mem_w_en = w; hit = h; cache_rdata = crd;
    glitch_ready = (glitch_at == 0);
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (sram_read) begin o.n_rd++; obs_addr_q.push_back(sram_addr); end
      if (sram_write) begin o.n_wr++; obs_addr_q.push_back(sram_addr); obs_wdata_q.push_back(sram_wdata); end
      if (cache_fill_en) o.n_fill++;
      if (cache_invalidate) o.n_inv++;
      if (cache_update) o.n_upd++;
      if (u_cache_invalidate) o.n_inv_u++;
      if (u_cache_update) o.n_upd_u++;
      if (ready) begin o.lat = c; o.rd = rdata; break; end
      @(posedge clk); #1;
      glitch_ready = (c + 1 == glitch_at);
      // Disturb request inputs after capture; the DUT must keep using captured values
      if (c == 0) begin addr = ~a; wdata = ~wd; hit = ~h; end
    end
    glitch_ready = 1'b0;
  endtask

  task automatic idle_bus();
    @(posedge clk); #1;
    mem_r_en = 1'b0; mem_w_en = 1'b0; hit = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_r_en = 1'b0; mem_w_en = 1'b0; hit = 1'b0; glitch_ready = 1'b0;
    addr = '0; wdata = '0; cache_rdata = '0;
    #1;
    checks++; if ({sram_read, sram_write, cache_fill_en, cache_invalidate, cache_update, cache_r_en} !== 6'b0) begin errors++; $display("FAIL reset_strobes: got %b required 000000", {sram_read, sram_write, cache_fill_en, cache_invalidate, cache_update, cache_r_en}); end
    checks++; if (cache_fill_data !== '0 || cache_fill_addr !== '0) begin errors++; $display("FAIL reset_capture: got data %h addr %h required 0", cache_fill_data, cache_fill_addr); end
    checks++; if (u_cache_update !== 1'b0) begin errors++; $display("FAIL reset_update_u: got %b required 0", u_cache_update); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    checks++; if (ready !== 1'b1 || rdata !== '0) begin errors++; $display("FAIL reset_idle_ready: got ready %b rdata %h required 1 / 0", ready, rdata); end
  endtask

  task automatic test_hit();
    exp_rd_q.push_back(32'hDEADBEEF);
    run_req(1, 0, 32'h40, 32'h0, 1, 32'hDEADBEEF, -1, res);
    checks++; if (cache_r_en !== 1'b1) begin errors++; $display("FAIL hit_r_en: got %b required 1", cache_r_en); end
    er = exp_rd_q.pop_front();
    checks++; if (res.lat !== 0) begin errors++; $display("FAIL hit_latency: got %0d required 0", res.lat); end
    checks++; if (res.rd !== er) begin errors++; $display("FAIL hit_rdata: got %h required %h", res.rd, er); end
    checks++; if (res.n_rd !== 0) begin errors++; $display("FAIL hit_no_sram_read: got %0d required 0", res.n_rd); end
    idle_bus();
  endtask

  task automatic test_miss(input logic [AW-1:0] a, input int lat);
    sram_lat = lat;
    exp_addr_q.push_back(line_base(a));
    exp_addr_q.push_back(line_base(a) | 17'h1);
    exp_rd_q.push_back(exp_word(a));
    run_req(1, 0, a, 32'h0, 0, 32'h0, -1, res);
    er = exp_rd_q.pop_front();
    checks++; if (res.lat !== LB * (lat + 1) + 1) begin errors++; $display("FAIL miss_latency: got %0d required %0d", res.lat, LB * (lat + 1) + 1); end
    checks++; if (res.rd !== er) begin errors++; $display("FAIL miss_rdata: got %h required %h", res.rd, er); end
    checks++; if (res.n_fill !== 1 || res.n_rd !== 2 || res.n_wr !== 0) begin errors++; $display("FAIL miss_strobes: got fill %0d rd %0d wr %0d required 1 2 0", res.n_fill, res.n_rd, res.n_wr); end
    checks++; if (cache_fill_data !== {beat_data(line_base(a) | 17'h1), beat_data(line_base(a))}) begin errors++; $display("FAIL miss_fill_data: got %h", cache_fill_data); end
    checks++; if (cache_fill_addr !== a) begin errors++; $display("FAIL miss_fill_addr: got %h required %h", cache_fill_addr, a); end
    while (exp_addr_q.size() != 0) begin
      ea = exp_addr_q.pop_front(); oa = (obs_addr_q.size() != 0) ? obs_addr_q.pop_front() : 'x;
      checks++; if (oa !== ea) begin errors++; $display("FAIL miss_sram_addr: got %h required %h", oa, ea); end
    end
    obs_addr_q.delete();
    idle_bus();
  endtask

  task automatic test_write(input logic [AW-1:0] a, input logic [DW-1:0] wd, input bit h, input int lat);
    sram_lat = lat;
    exp_addr_q.push_back(SAW'(a >> 3));
    exp_rd_q.push_back(32'h0);
    run_req(0, 1, a, wd, h, 32'h0, -1, res);
    er = exp_rd_q.pop_front();
    checks++; if (res.lat !== lat + 2) begin errors++; $display("FAIL write_latency: got %0d required %0d", res.lat, lat + 2); end
    checks++; if (res.rd !== er) begin errors++; $display("FAIL write_rdata: got %h required %h", res.rd, er); end
    checks++; if (res.n_wr !== 1 || res.n_rd !== 0 || res.n_fill !== 0) begin errors++; $display("FAIL write_strobes: got wr %0d rd %0d fill %0d required 1 0 0", res.n_wr, res.n_rd, res.n_fill); end
    checks++; if (res.n_inv !== 1 || res.n_upd !== 0) begin errors++; $display("FAIL write_invalidate: got inv %0d upd %0d required 1 0", res.n_inv, res.n_upd); end
    checks++; if (res.n_upd_u !== int'(h) || res.n_inv_u !== 0) begin errors++; $display("FAIL write_update_u: got upd %0d inv %0d required %0d 0", res.n_upd_u, res.n_inv_u, int'(h)); end
    ea = exp_addr_q.pop_front(); oa = (obs_addr_q.size() != 0) ? obs_addr_q.pop_front() : 'x;
    checks++; if (oa !== ea) begin errors++; $display("FAIL write_sram_addr: got %h required %h", oa, ea); end
    er = (obs_wdata_q.size() != 0) ? obs_wdata_q.pop_front() : 'x;
    checks++; if (er !== wd) begin errors++; $display("FAIL write_sram_wdata: got %h required %h", er, wd); end
    obs_addr_q.delete(); obs_wdata_q.delete();
    idle_bus();
  endtask

  task automatic test_both_enables();
    sram_lat = 1;
    exp_rd_q.push_back(exp_word(32'h208));
    run_req(1, 1, 32'h208, 32'hFFFF_0000, 0, 32'h0, -1, res);
    er = exp_rd_q.pop_front();
    checks++; if (res.n_wr !== 0 || res.n_rd !== 2) begin errors++; $display("FAIL both_read_priority: got wr %0d rd %0d required 0 2", res.n_wr, res.n_rd); end
    checks++; if (res.rd !== er || res.lat !== 5) begin errors++; $display("FAIL both_rdata: got %h lat %0d required %h lat 5", res.rd, res.lat, er); end
    obs_addr_q.delete(); obs_wdata_q.delete();
    idle_bus();
  endtask

  task automatic test_back_to_back();
    sram_lat = 1;
    exp_rd_q.push_back(exp_word(32'h0000_1F3C));
    exp_rd_q.push_back(32'h1234_5678);
    exp_rd_q.push_back(32'h0);
    exp_rd_q.push_back(exp_word(32'h108));
    run_req(1, 0, 32'h0000_1F3C, 32'h0, 0, 32'h0, -1, res);
    er = exp_rd_q.pop_front();
    checks++; if (res.rd !== er || res.lat !== 5) begin errors++; $display("FAIL b2b_miss: got %h lat %0d required %h lat 5", res.rd, res.lat, er); end
    run_req(1, 0, 32'h80, 32'h0, 1, 32'h1234_5678, -1, res);
    er = exp_rd_q.pop_front();
    checks++; if (res.rd !== er || res.lat !== 0) begin errors++; $display("FAIL b2b_hit: got %h lat %0d required %h lat 0", res.rd, res.lat, er); end
    run_req(0, 1, 32'h30, 32'hCAFE_F00D, 0, 32'h0, -1, res);
    er = exp_rd_q.pop_front();
    checks++; if (res.rd !== er || res.lat !== 3) begin errors++; $display("FAIL b2b_write: got %h lat %0d required %h lat 3", res.rd, res.lat, er); end
    run_req(1, 0, 32'h108, 32'h0, 0, 32'h0, -1, res);
    er = exp_rd_q.pop_front();
    checks++; if (res.rd !== er || res.lat !== 5) begin errors++; $display("FAIL b2b_miss2: got %h lat %0d required %h lat 5", res.rd, res.lat, er); end
    obs_addr_q.delete(); obs_wdata_q.delete();
    idle_bus();
  endtask

  task automatic test_glitch();
    glitch_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (ready !== 1'b1 || sram_read !== 1'b0) begin errors++; $display("FAIL glitch_idle: got ready %b sram_read %b required 1 0", ready, sram_read); end
    end
    glitch_ready = 1'b0;
    sram_lat = 2;
    exp_addr_q.push_back(line_base(32'h0000_0A0C));
    exp_addr_q.push_back(line_base(32'h0000_0A0C) | 17'h1);
    exp_rd_q.push_back(exp_word(32'h0000_0A0C));
    run_req(1, 0, 32'h0000_0A0C, 32'h0, 0, 32'h0, 1, res);
    er = exp_rd_q.pop_front();
    checks++; if (res.lat !== 7 || res.n_rd !== 2) begin errors++; $display("FAIL glitch_rdreq: got lat %0d rd %0d required 7 2", res.lat, res.n_rd); end
    checks++; if (res.rd !== er) begin errors++; $display("FAIL glitch_rdata: got %h required %h", res.rd, er); end
    while (exp_addr_q.size() != 0) begin
      ea = exp_addr_q.pop_front(); oa = (obs_addr_q.size() != 0) ? obs_addr_q.pop_front() : 'x;
      checks++; if (oa !== ea) begin errors++; $display("FAIL glitch_sram_addr: got %h required %h", oa, ea); end
    end
    obs_addr_q.delete();
    idle_bus();
  endtask

  task automatic test_reset_midfill();
    int n_strobe, n_fill;
    sram_lat = 2;
    @(posedge clk); #1;
    addr = 32'h108; mem_r_en = 1'b1; mem_w_en = 1'b0; hit = 1'b0;
    n_strobe = 0;
    for (int c = 0; c < 40 && n_strobe < 2; c++) begin
      @(negedge clk);
      if (sram_read) n_strobe++;
    end
    checks++; if (n_strobe !== 2) begin errors++; $display("FAIL midfill_second_beat: got %0d strobes required 2", n_strobe); end
    @(posedge clk); #3 rst = 1'b1; #1;
    checks++; if ({sram_read, sram_write, cache_fill_en, cache_invalidate, cache_update, cache_r_en, ready} !== 7'b0) begin errors++; $display("FAIL midfill_reset_outputs: got %b required 0000000", {sram_read, sram_write, cache_fill_en, cache_invalidate, cache_update, cache_r_en, ready}); end
    checks++; if (cache_fill_data !== '0 || rdata !== '0) begin errors++; $display("FAIL midfill_reset_buffer: got %h rdata %h required 0", cache_fill_data, rdata); end
    n_fill = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (cache_fill_en || u_cache_fill_en) n_fill++;
    end
    mem_r_en = 1'b0;
    rst = 1'b0;
    checks++; if (n_fill !== 0) begin errors++; $display("FAIL midfill_no_fill: got %0d required 0", n_fill); end
    obs_addr_q.delete();
    sram_lat = 1;
    exp_addr_q.push_back(17'h20);
    exp_rd_q.push_back(32'h1111_2222);
    run_req(1, 0, 32'h108, 32'h0, 0, 32'h0, -1, res);
    er = exp_rd_q.pop_front();
    ea = exp_addr_q.pop_front(); oa = (obs_addr_q.size() != 0) ? obs_addr_q.pop_front() : 'x;
    checks++; if (oa !== ea) begin errors++; $display("FAIL midfill_restart_beat0: got %h required %h", oa, ea); end
    checks++; if (res.rd !== er || res.lat !== 5 || res.n_fill !== 1) begin errors++; $display("FAIL midfill_restart: got %h lat %0d fill %0d required %h 5 1", res.rd, res.lat, res.n_fill, er); end
    obs_addr_q.delete();
    idle_bus();
  endtask

  initial begin
    test_reset();
    test_hit();
    test_miss(32'h0000_0108, 1);
    test_miss(32'h0000_1F3C, 3);
    test_write(32'h10, 32'h5A5A_5A5A, 1, 1);
    test_write(32'h24, 32'h0F0F_0F0F, 0, 2);
    test_both_enables();
    test_back_to_back();
    test_glitch();
    test_reset_midfill();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
